// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8-way round-robin mux select arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit at or after ptr (mod 8),
// optionally skipping mask_idx.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [SEL_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk the offsets downwards so the smallest offset from ptr wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[SEL_W-1:0];
      if (req[cand] && !(mask_en && (cand == mask_idx))) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select lines with registered outputs.
// Optional burst cap compiled in with `define MUX8_RR_ARBITER_BURST_LIMIT_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] cur_id
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("MAX_BURST out of range 1..255");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             take;

`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // The current owner is masked so a burst handover never re-picks it.
  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .mask_idx (idx_q),
    .mask_en  (state_q == GRANT),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    take    = 1'b0;
`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) take = 1'b1;
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
        else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          if (pick_found) take = 1'b1;
          else            cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = GRANT;
      idx_d   = pick_idx;
      ptr_d   = pick_idx + 1'b1;
      gnt_d   = onehot8(pick_idx);
`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
`ifdef MUX8_RR_ARBITER_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = idx_q;
  assign cur_id    = idx_q;
  assign gnt_valid = (state_q == GRANT);

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the 8:1 multiplexer (`m81`). Eight requesters compete for the shared mux output. The block grants exactly one requester at a time and drives the mux select lines to that requester's input index. It holds each grant for the requester's whole transaction, with an optional burst cap. It sits directly in front of the mux select pins and replaces free-running select stimulus with a controlled, fair schedule.

## Interface
Clock domain: one clock; reset is synchronous and active-high.

Parameters:
- MAX_BURST, 4 — maximum consecutive grant cycles per winner when the burst limit is compiled in; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  8  request vector; req[i] high = input Di wants the mux output
- gnt  out  8  one-hot grant; all-zero when idle
- sel  out  3  mux select {S2,S1,S0} = index of the granted input
- gnt_valid  out  1  high whenever gnt is non-zero
- cur_id  out  3  index of the most recent winner, for debug and visibility

## Operation
- Two states:
  - IDLE: gnt=0, gnt_valid=0.
  - GRANT: gnt=one-hot(idx), gnt_valid=1.
- sel and cur_id hold the last granted index in IDLE. They are never X.
- Round-robin pointer ptr (3 bits): search starts at ptr and runs ptr, ptr+1, …, ptr+7 mod 8. The first set req bit wins.
- On every new grant, ptr becomes winner+1 mod 8. Wrap from 7 goes to 0.
- IDLE -> GRANT: when any req bit is sampled high. The winner is chosen by the pick above.
- In GRANT, the grant holds while req[idx] stays high (subject to the burst limit).
- On req[idx] sampled low:
  - If any other req bit is high, switch directly to the next winner on the same edge. There is no idle bubble.
  - Otherwise go to IDLE.
- A requester that drops and re-raises req loses its turn and waits its round-robin turn.
- Reset values: state=IDLE, gnt=0, sel=0, gnt_valid=0, cur_id=0, ptr=0, burst count=0.
- Reset asserted mid-grant clears everything on that edge. The grant is not resumed afterwards.
- Simultaneous release of the owner and requests from others: the next winner is chosen from the requests sampled on that edge, excluding the released owner.

## Timing
- All outputs are registered.
- A req sampled high at edge t in IDLE produces gnt/sel/gnt_valid valid after edge t. Latency is one cycle from req assertion to grant.
- Release: req[idx] low sampled at edge t updates gnt after edge t (handover to the next winner, or to IDLE). The owner therefore sees its grant for one cycle after dropping req.
- sel changes only on the same edge as gnt, so the mux output is glitch-free with respect to grant.
- No combinational path from req to any output.

## Configuration
- Macro: MUX8_RR_ARBITER_BURST_LIMIT_EN.
- Defined:
  - An 8-bit burst counter resets to 0 on each new grant and increments each GRANT cycle.
  - When the count reaches MAX_BURST-1 and at least one other req bit is high, the grant is forcibly handed to the next round-robin winner on the next edge.
  - If no other requester is pending, the counter restarts at 0 and the owner keeps the grant.
- Not defined: no counter exists, and the grant is held until the owner drops req. MAX_BURST is ignored.

## Structure
- Package mux8_arb_pkg holds:
  - N_REQ=8 and SEL_W=3
  - the state enum (IDLE, GRANT)
  - the burst counter width constant
- Sub-module rr_pick8 is purely combinational: inputs req[7:0], ptr[2:0], mask_idx[2:0], mask_en; outputs idx[2:0], found. It is instantiated once.
- The top level holds the FSM, ptr, the burst counter and the output registers.

## Test plan
- Reset then a single request:
  - rst high 2 cycles, then req=8'h00 -> gnt=0, sel=0, gnt_valid=0.
  - req=8'h10 at edge t -> gnt=8'h10, sel=4 after t.
- Full contention rotation: req=8'hFF held, each owner dropping its req for one cycle after 3 grant cycles -> grant order 0,1,2,…,7,0, with sel tracking and no idle cycle between owners.
- Wrap and skip: ptr=6 and req=8'h05 -> winner 0, then 2.
- Reset mid-grant: rst during a grant to input 3 -> gnt=0 and ptr=0 next cycle; with req=8'h08 still high, the grant returns to 3 one cycle after rst falls.
- Burst limit (macro defined, MAX_BURST=4), two cases:
  - req=8'h03 held -> 0 granted 4 cycles, then 1 for 4 cycles, alternating.
  - req=8'h01 alone -> 0 held indefinitely.
- Burst limit off (macro undefined): req=8'h03 held -> 0 keeps the grant indefinitely; 1 is granted only after req[0] falls.
